// File: rtl/mo_lb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mo_lb_pkg
// Brief    : Shared types and constants for the motion-object line buffer.
// Revision : 1.0 - initial release
// ============================================================================
package mo_lb_pkg;

    localparam int          PW     = 7;
    localparam int          HPIX_W = 9;
    localparam logic [3:0]  TRANSP = 4'hF;

    // [3:0] colour, [6:4] palette
    typedef logic [PW-1:0] mo_pix_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        CHECK = 2'd2
    } draw_state_t;

endpackage
`default_nettype wire

// File: rtl/mo_lb_bank.sv
`default_nettype none
// ============================================================================
// Module   : mo_lb_bank
// Brief    : One line-buffer bank: simple dual-port RAM, registered read.
// Revision : 1.0 - initial release
// ============================================================================
module mo_lb_bank
    import mo_lb_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [HPIX_W-1:0] i_waddr,
    input  mo_pix_t           i_wdata,
    input  logic [HPIX_W-1:0] i_raddr,
    output mo_pix_t           o_rdata
);

    mo_pix_t r_mem [DEPTH];
    mo_pix_t r_rdata;

    // Read returns the pre-write contents when addresses collide.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mo_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mo_line_buffer
// Brief    : Ping-pong MO line buffer; draw into one bank, scan/clear the other.
//            Define MO_LB_PRIO_EN for first-drawn-wins read-modify-write draws.
// Revision : 1.0 - initial release
// ============================================================================
module mo_line_buffer
    import mo_lb_pkg::*;
#(
    parameter int HPIX = 512,
    parameter int HVIS = 336
) (
    input  logic              MCKR,
    input  logic              RESET,
    input  logic              LINE_SWAP,
    input  logic              BUFCLR_b,
    input  logic              MO_LD,
    input  logic [HPIX_W-1:0] MO_HPOS,
    input  logic              MO_PIX_VLD,
    input  mo_pix_t           MOSR,
    input  logic              MO_END,
    output logic              MO_RDY,
    output logic              MO_DROP,
    input  logic [HPIX_W-1:0] HCOUNT,
    output mo_pix_t           MPX,
    output logic              PADB
);

    localparam mo_pix_t            c_transp_pix = mo_pix_t'(TRANSP);
    localparam logic [HPIX_W:0]    c_hvis       = (HPIX_W+1)'(HVIS);

    draw_state_t        r_state, w_state_nxt;
    logic [HPIX_W-1:0]  r_wptr, w_wptr_nxt;
    logic               r_padb, r_scan_valid, r_mo_drop, w_mo_drop_nxt;
    logic               r_mpx_force, r_scan_sel;
    logic               w_mo_rdy, w_draw_we, w_wptr_vis, w_scan_vis, w_scan_clr;
    mo_pix_t            w_draw_wdata;

    logic               w_we    [2];
    logic [HPIX_W-1:0]  w_waddr [2];
    mo_pix_t            w_wdata [2];
    logic [HPIX_W-1:0]  w_raddr [2];
    mo_pix_t            w_rdata [2];

`ifdef MO_LB_PRIO_EN
    mo_pix_t            r_pix, w_pix_nxt;
    logic               r_end, w_end_nxt;
    mo_pix_t            w_draw_rdata;

    assign w_draw_rdata = w_rdata[r_padb];
`endif

    assign w_wptr_vis = {1'b0, r_wptr} < c_hvis;
    assign w_scan_vis = {1'b0, HCOUNT} < c_hvis;
    assign w_scan_clr = BUFCLR_b & w_scan_vis;

    always_comb begin
        w_state_nxt   = r_state;
        w_wptr_nxt    = r_wptr;
        w_mo_drop_nxt = 1'b0;
        w_mo_rdy      = 1'b0;
        w_draw_we     = 1'b0;
        w_draw_wdata  = MOSR;
`ifdef MO_LB_PRIO_EN
        w_pix_nxt     = r_pix;
        w_end_nxt     = r_end;
        w_draw_wdata  = r_pix;
`endif
        case (r_state)
            IDLE: begin
                if (MO_LD) begin
                    w_wptr_nxt  = MO_HPOS;
                    w_state_nxt = DRAW;
                end
            end
            DRAW: begin
                w_mo_rdy = 1'b1;
                if (MO_LD) begin
                    w_wptr_nxt = MO_HPOS;
                end else begin
`ifdef MO_LB_PRIO_EN
                    // Accepted pixel reads the location now, decides in CHECK.
                    if (MO_PIX_VLD) begin
                        w_pix_nxt   = MOSR;
                        w_end_nxt   = MO_END;
                        w_state_nxt = CHECK;
                    end else if (MO_END) begin
                        w_state_nxt = IDLE;
                    end
`else
                    if (MO_PIX_VLD) begin
                        w_draw_we  = (MOSR[3:0] != TRANSP) && w_wptr_vis;
                        w_wptr_nxt = r_wptr + 1'b1;
                    end
                    if (MO_END) begin
                        w_state_nxt = IDLE;
                    end
`endif
                end
                if (LINE_SWAP) begin
                    w_state_nxt   = IDLE;
                    w_mo_drop_nxt = 1'b1;
                end
            end
`ifdef MO_LB_PRIO_EN
            CHECK: begin
                if (MO_LD) begin
                    w_wptr_nxt  = MO_HPOS;
                    w_state_nxt = DRAW;
                end else begin
                    w_draw_we   = (r_pix[3:0] != TRANSP) && w_wptr_vis &&
                                  (w_draw_rdata[3:0] == TRANSP);
                    w_wptr_nxt  = r_wptr + 1'b1;
                    w_state_nxt = r_end ? IDLE : DRAW;
                end
                if (LINE_SWAP) begin
                    w_state_nxt   = IDLE;
                    w_mo_drop_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge MCKR) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_wptr       <= '0;
            r_mo_drop    <= 1'b0;
            r_padb       <= 1'b0;
            r_scan_valid <= 1'b0;
            r_mpx_force  <= 1'b1;
            r_scan_sel   <= 1'b1;
`ifdef MO_LB_PRIO_EN
            r_pix        <= c_transp_pix;
            r_end        <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_wptr       <= w_wptr_nxt;
            r_mo_drop    <= w_mo_drop_nxt;
            r_mpx_force  <= !r_scan_valid || !w_scan_vis;
            r_scan_sel   <= ~r_padb;
            if (LINE_SWAP) begin
                r_padb       <= ~r_padb;
                r_scan_valid <= 1'b1;
            end
`ifdef MO_LB_PRIO_EN
            r_pix        <= w_pix_nxt;
            r_end        <= w_end_nxt;
`endif
        end
    end

    // Bank b is the draw bank when PADB == b, otherwise the scan bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_is_draw;
        assign w_is_draw  = (r_padb == 1'(b));
        assign w_we[b]    = w_is_draw ? w_draw_we    : w_scan_clr;
        assign w_waddr[b] = w_is_draw ? r_wptr       : HCOUNT;
        assign w_wdata[b] = w_is_draw ? w_draw_wdata : c_transp_pix;
        assign w_raddr[b] = w_is_draw ? r_wptr       : HCOUNT;

        mo_lb_bank #(
            .DEPTH (HPIX)
        ) u_bank (
            .clk     (MCKR),
            .i_we    (w_we[b]),
            .i_waddr (w_waddr[b]),
            .i_wdata (w_wdata[b]),
            .i_raddr (w_raddr[b]),
            .o_rdata (w_rdata[b])
        );
    end

    assign MO_RDY  = w_mo_rdy;
    assign MO_DROP = r_mo_drop;
    assign PADB    = r_padb;
    assign MPX     = r_mpx_force ? c_transp_pix : w_rdata[r_scan_sel];

endmodule
`default_nettype wire

// File: tb/tb_mo_line_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mo_line_buffer
// Brief    : Directed self-checking bench for mo_line_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mo_line_buffer;
    import mo_lb_pkg::*;

    localparam logic [6:0] T = 7'h0F;

    logic       MCKR = 1'b0;
    logic       RESET, LINE_SWAP, BUFCLR_b, MO_LD, MO_PIX_VLD, MO_END;
    logic [8:0] MO_HPOS, HCOUNT;
    logic [6:0] MOSR, MPX;
    logic       MO_RDY, MO_DROP, PADB;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 MCKR = ~MCKR;

    mo_line_buffer dut (
        .MCKR       (MCKR),
        .RESET      (RESET),
        .LINE_SWAP  (LINE_SWAP),
        .BUFCLR_b   (BUFCLR_b),
        .MO_LD      (MO_LD),
        .MO_HPOS    (MO_HPOS),
        .MO_PIX_VLD (MO_PIX_VLD),
        .MOSR       (MOSR),
        .MO_END     (MO_END),
        .MO_RDY     (MO_RDY),
        .MO_DROP    (MO_DROP),
        .HCOUNT     (HCOUNT),
        .MPX        (MPX),
        .PADB       (PADB)
    );

    task automatic tick();
        @(posedge MCKR);
        #1;
    endtask

    task automatic do_swap();
        LINE_SWAP = 1'b1;
        tick();
        LINE_SWAP = 1'b0;
    endtask

    task automatic scan_line(input logic clr);
        BUFCLR_b = clr;
        for (int h = 0; h < 512; h++) begin
            HCOUNT = 9'(h);
            tick();
        end
        HCOUNT   = 9'd511;
        BUFCLR_b = 1'b1;
    endtask

    task automatic draw_strip(input logic [8:0] hpos, input int n,
                              input logic [6:0] first, input logic with_end);
        MO_HPOS = hpos;
        MO_LD   = 1'b1;
        tick();
        MO_LD   = 1'b0;
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            while (MO_RDY !== 1'b1 && guard < 8) begin
                tick();
                guard++;
            end
            if (guard == 8) begin
                n_tests++;
                n_fail++;
                $display("FAIL draw_rdy_timeout: MO_RDY=%b required 1", MO_RDY);
            end
            MOSR       = first + 7'(i);
            MO_PIX_VLD = 1'b1;
            MO_END     = with_end && (i == n - 1);
            tick();
            MO_PIX_VLD = 1'b0;
            MO_END     = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        n_tests++; if (PADB !== 1'b0) begin n_fail++; $display("FAIL reset_padb: got %b required 0", PADB); end
        n_tests++; if (MPX !== T) begin n_fail++; $display("FAIL reset_mpx: got %h required %h", MPX, T); end
        n_tests++; if (MO_RDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b required 0", MO_RDY); end
        n_tests++; if (MO_DROP !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b required 0", MO_DROP); end
        RESET = 1'b0;
        for (int h = 0; h < 512; h++) begin
            HCOUNT = 9'(h);
            tick();
            n_tests++;
            if (MPX !== T) begin n_fail++; $display("FAIL pre_swap_mpx h=%0d: got %h required %h", h, MPX, T); end
        end
        n_tests++; if (PADB !== 1'b0) begin n_fail++; $display("FAIL pre_swap_padb: got %b required 0", PADB); end
        HCOUNT = 9'd511;
        // Clear bank A too so later reads see only what the tests draw.
        do_swap();
        n_tests++; if (PADB !== 1'b1) begin n_fail++; $display("FAIL first_swap_padb: got %b required 1", PADB); end
        scan_line(1'b1);
        do_swap();
    endtask

    task automatic test_draw_scan();
        draw_strip(9'd100, 8, 7'h12, 1'b1);
        do_swap();
        for (int h = 99; h <= 108; h++) begin
            logic [6:0] exp;
            exp = (h >= 100 && h <= 107) ? 7'(7'h12 + h - 100) : T;
            HCOUNT = 9'(h);
            tick();
            n_tests++;
            if (MPX !== exp) begin n_fail++; $display("FAIL scan1 h=%0d: got %h required %h", h, MPX, exp); end
        end
        HCOUNT = 9'd511;
        do_swap();
        do_swap();
        n_tests++; if (PADB !== 1'b1) begin n_fail++; $display("FAIL scan2_padb: got %b required 1", PADB); end
        for (int h = 100; h <= 107; h++) begin
            HCOUNT = 9'(h);
            tick();
            n_tests++;
            if (MPX !== T) begin n_fail++; $display("FAIL cleared h=%0d: got %h required %h", h, MPX, T); end
        end
        HCOUNT = 9'd511;
    endtask

    task automatic test_freeze();
        draw_strip(9'd100, 8, 7'h12, 1'b1);
        do_swap();
        for (int pass = 0; pass < 3; pass++) begin
            BUFCLR_b = (pass != 0);
            for (int h = 100; h <= 107; h++) begin
                logic [6:0] exp;
                exp = (pass < 2) ? 7'(7'h12 + h - 100) : T;
                HCOUNT = 9'(h);
                tick();
                n_tests++;
                if (MPX !== exp) begin n_fail++; $display("FAIL freeze p%0d h=%0d: got %h required %h", pass, h, MPX, exp); end
            end
            HCOUNT   = 9'd511;
            BUFCLR_b = 1'b1;
            do_swap();
            do_swap();
        end
        n_tests++; if (PADB !== 1'b0) begin n_fail++; $display("FAIL freeze_padb: got %b required 0", PADB); end
    endtask

    task automatic test_wrap();
        logic [8:0] addr [5];
        logic [6:0] exp  [5];
        addr = '{9'd510, 9'd511, 9'd0, 9'd1, 9'd2};
        exp  = '{T, T, 7'h43, 7'h44, T};
        draw_strip(9'd510, 4, 7'h41, 1'b1);
        do_swap();
        for (int i = 0; i < 5; i++) begin
            HCOUNT = addr[i];
            tick();
            n_tests++;
            if (MPX !== exp[i]) begin n_fail++; $display("FAIL wrap h=%0d: got %h required %h", addr[i], MPX, exp[i]); end
        end
        HCOUNT = 9'd511;
    endtask

    task automatic test_drop();
        draw_strip(9'd50, 3, 7'h51, 1'b0);
        n_tests++; if (MO_RDY !== 1'b1) begin n_fail++; $display("FAIL drop_pre_rdy: got %b required 1", MO_RDY); end
        do_swap();
        n_tests++; if (MO_DROP !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b required 1", MO_DROP); end
        n_tests++; if (MO_RDY !== 1'b0) begin n_fail++; $display("FAIL drop_idle_rdy: got %b required 0", MO_RDY); end
        n_tests++; if (PADB !== 1'b0) begin n_fail++; $display("FAIL drop_padb: got %b required 0", PADB); end
        MOSR       = 7'h54;
        MO_PIX_VLD = 1'b1;
        tick();
        n_tests++; if (MO_DROP !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle: got %b required 0", MO_DROP); end
        tick();
        MO_PIX_VLD = 1'b0;
        for (int h = 50; h <= 53; h++) begin
            logic [6:0] exp;
            exp = (h <= 52) ? 7'(7'h51 + h - 50) : T;
            HCOUNT = 9'(h);
            tick();
            n_tests++;
            if (MPX !== exp) begin n_fail++; $display("FAIL drop_scan h=%0d: got %h required %h", h, MPX, exp); end
        end
        HCOUNT = 9'd511;
        do_swap();
        HCOUNT = 9'd53;
        tick();
        n_tests++; if (MPX !== T) begin n_fail++; $display("FAIL drop_ignored: got %h required %h", MPX, T); end
        HCOUNT = 9'd511;
    endtask

    task automatic test_overlap();
        logic       rdy_after_pix;
        logic [6:0] exp;
`ifdef MO_LB_PRIO_EN
        rdy_after_pix = 1'b0;
        exp           = 7'h21;
`else
        rdy_after_pix = 1'b1;
        exp           = 7'h35;
`endif
        MO_HPOS = 9'd200;
        MO_LD   = 1'b1;
        tick();
        MO_LD   = 1'b0;
        n_tests++; if (MO_RDY !== 1'b1) begin n_fail++; $display("FAIL ovl_rdy0: got %b required 1", MO_RDY); end
        MOSR       = 7'h21;
        MO_PIX_VLD = 1'b1;
        tick();
        MO_PIX_VLD = 1'b0;
        n_tests++; if (MO_RDY !== rdy_after_pix) begin n_fail++; $display("FAIL ovl_rdy1: got %b required %b", MO_RDY, rdy_after_pix); end
        tick();
        n_tests++; if (MO_RDY !== 1'b1) begin n_fail++; $display("FAIL ovl_rdy2: got %b required 1", MO_RDY); end
        MO_END = 1'b1;
        tick();
        MO_END = 1'b0;
        n_tests++; if (MO_RDY !== 1'b0) begin n_fail++; $display("FAIL ovl_end_idle: got %b required 0", MO_RDY); end
        draw_strip(9'd200, 1, 7'h35, 1'b1);
        do_swap();
        HCOUNT = 9'd200;
        tick();
        n_tests++; if (MPX !== exp) begin n_fail++; $display("FAIL overlap: got %h required %h", MPX, exp); end
        HCOUNT = 9'd511;
    endtask

    task automatic test_reset_mid_strip();
        do_swap();
        MO_HPOS = 9'd10;
        MO_LD   = 1'b1;
        tick();
        MO_LD      = 1'b0;
        MOSR       = 7'h22;
        MO_PIX_VLD = 1'b1;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        n_tests++; if (MO_RDY !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rdy: got %b required 0", MO_RDY); end
        n_tests++; if (PADB !== 1'b0) begin n_fail++; $display("FAIL rst_mid_padb: got %b required 0", PADB); end
        tick();
        MO_PIX_VLD = 1'b0;
        n_tests++; if (MO_DROP !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drop: got %b required 0", MO_DROP); end
        n_tests++; if (MO_RDY !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stay_idle: got %b required 0", MO_RDY); end
        HCOUNT = 9'd10;
        tick();
        n_tests++; if (MPX !== T) begin n_fail++; $display("FAIL rst_mid_mpx: got %h required %h", MPX, T); end
    endtask

    initial begin
        RESET      = 1'b1;
        LINE_SWAP  = 1'b0;
        BUFCLR_b   = 1'b1;
        MO_LD      = 1'b0;
        MO_HPOS    = '0;
        MO_PIX_VLD = 1'b0;
        MOSR       = '0;
        MO_END     = 1'b0;
        HCOUNT     = '0;
        test_reset();
        test_draw_scan();
        test_freeze();
        test_wrap();
        test_drop();
        test_overlap();
        test_reset_mid_strip();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
